// File: rtl/traffic_light_fsm.sv
// Three-phase traffic light controller (RED -> GREEN -> AMBER) timed by an external
// phase counter, with a synchronised pedestrian request that shortens GREEN and earns a walk phase.
module traffic_light_fsm #(
  parameter int unsigned RED_LEN       = 10,
  parameter int unsigned GREEN_LEN     = 8,
  parameter int unsigned AMBER_LEN     = 4,
  parameter int unsigned PED_GREEN_MIN = 3
) (
  input  logic       second_clk,
  input  logic       reset,
  input  logic       pedestrian,
  input  logic [3:0] counter_reg,
  output logic [1:0] currColour,
  output logic       counter_clear,
  output logic       ped_pending,
  output logic       ped_walk
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RED_TERM   = CNT_W'(RED_LEN - 1);
  localparam logic [CNT_W-1:0] GREEN_TERM = CNT_W'(GREEN_LEN - 1);
  localparam logic [CNT_W-1:0] AMBER_TERM = CNT_W'(AMBER_LEN - 1);
  localparam logic [CNT_W-1:0] PED_TERM   = CNT_W'(PED_GREEN_MIN - 1);

  // State encoding doubles as the colour code, so currColour is the state register itself.
  typedef enum logic [1:0] {
    ST_RED   = 2'b00,
    ST_AMBER = 2'b01,
    ST_GREEN = 2'b11
  } state_e;

  state_e state_q, state_d;
  logic   clear_q, clear_d;
  logic   pend_q, pend_d;
  logic   walk_q, walk_d;
  logic   sync1_q, sync2_q, prev_q;
  logic   ped_edge_c;
  logic   cnt_valid_c;

  assign ped_edge_c  = sync2_q & ~prev_q;
  // A stale count from the previous phase is visible during the clear cycle; ignore it.
  assign cnt_valid_c = ~clear_q;

  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    pend_d  = pend_q;
    walk_d  = walk_q;

    if (ped_edge_c && !(state_q == ST_RED && walk_q)) begin
      pend_d = 1'b1;
    end

    // Comparisons use >= so an overrunning counter still ends the phase.
    case (state_q)
      ST_RED: begin
        if (cnt_valid_c && counter_reg >= RED_TERM) begin
          state_d = ST_GREEN;
          clear_d = 1'b1;
          walk_d  = 1'b0;
        end
      end
      ST_GREEN: begin
        if (cnt_valid_c && (counter_reg >= GREEN_TERM || (pend_q && counter_reg >= PED_TERM))) begin
          state_d = ST_AMBER;
          clear_d = 1'b1;
        end
      end
      ST_AMBER: begin
        if (cnt_valid_c && counter_reg >= AMBER_TERM) begin
          state_d = ST_RED;
          clear_d = 1'b1;
          walk_d  = pend_q | ped_edge_c;
          pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_RED;
        clear_d = 1'b1;
        walk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge second_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RED;
      clear_q <= 1'b1;
      pend_q  <= 1'b0;
      walk_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      pend_q  <= pend_d;
      walk_q  <= walk_d;
      sync1_q <= pedestrian;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign currColour    = state_q;
  assign counter_clear = clear_q;
  assign ped_pending   = pend_q;
  assign ped_walk      = walk_q;

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter RED_LEN, default 10: RED dwell in second_clk cycles (counter_reg terminal = RED_LEN-1).
REQ-002 Parameter GREEN_LEN, default 8: normal GREEN dwell in cycles.
REQ-003 Parameter AMBER_LEN, default 4: AMBER dwell in cycles.
REQ-004 Parameter PED_GREEN_MIN, default 3: minimum GREEN dwell when a pedestrian request is pending.
REQ-005 second_clk  input  1: single clock; all state changes on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 pedestrian  input  1: raw, asynchronous pedestrian push-button, active-high.
REQ-008 counter_reg  input  4: current phase count from the downstream phase counter, unsigned.
REQ-009 currColour  output  2: current phase; RED=2'b00, AMBER=2'b01, GREEN=2'b11; 2'b10 never driven.
REQ-010 counter_clear  output  1: registered one-cycle pulse; the phase counter restarts at 0.
REQ-011 ped_pending  output  1: a pedestrian request is latched and not yet served.
REQ-012 ped_walk  output  1: walk indication; high for the whole RED phase that serves a request.

Function
REQ-013 The FSM SHALL have exactly three states, RED, GREEN and AMBER, sequenced RED -> GREEN -> AMBER -> RED.
REQ-014 currColour SHALL be a registered decode of the state, with no combinational path from any input.
REQ-015 RED SHALL exit at the edge after a cycle where counter_reg == RED_LEN-1 and counter_clear == 0.
REQ-016 GREEN SHALL exit at the edge after a cycle where counter_clear == 0 and either counter_reg == GREEN_LEN-1, or ped_pending == 1 and counter_reg >= PED_GREEN_MIN-1.
REQ-017 AMBER SHALL exit at the edge after a cycle where counter_reg == AMBER_LEN-1 and counter_clear == 0.
REQ-018 counter_clear SHALL be 1 for exactly the first cycle of every new phase and 0 otherwise.
REQ-019 Terminal detection SHALL be suppressed while counter_clear == 1, so a stale counter_reg cannot cause a back-to-back transition.
REQ-020 counter_reg values above the current phase terminal SHALL force the phase exit as if the terminal were reached (overrun recovery).
REQ-021 pedestrian SHALL pass through a 2-flop synchroniser, then a rising-edge detector; held or bouncing-high input SHALL produce one request per rising edge.
REQ-022 A detected edge SHALL set ped_pending on the next edge in GREEN or AMBER, and in RED when ped_walk == 0.
REQ-023 A detected edge in RED while ped_walk == 1 SHALL be ignored, as the request is already being served.
REQ-024 On the AMBER -> RED transition, ped_walk SHALL take the value of ped_pending, and ped_pending SHALL clear.
REQ-025 An edge detected in the same cycle as the AMBER -> RED transition SHALL be absorbed, so ped_pending ends at 0 and ped_walk at 1.
REQ-026 ped_walk SHALL clear on the RED -> GREEN transition.
REQ-027 An illegal state encoding SHALL return to RED with counter_clear asserted on the next edge.

Reset
REQ-028 While reset == 0, the block SHALL hold currColour = 2'b00, counter_clear = 1, ped_pending = 0, ped_walk = 0, and synchroniser/edge flops = 0, asynchronously.
REQ-029 On the first edge after reset deasserts, counter_clear SHALL drop to 0 and RED timing SHALL start from counter_reg = 0.
REQ-030 Reset asserted mid-phase or mid-request SHALL discard any pending request and restart in RED.

Verification
REQ-031 Free run, no pedestrian, ideal counter model -> RED 10 cycles, GREEN 8, AMBER 4, repeating; a counter_clear pulse at each phase start.
REQ-032 Pedestrian pulse at GREEN count 1 -> ped_pending = 1; GREEN exits after counter_reg = 2 (3 cycles); AMBER 4 cycles; RED with ped_walk = 1 and ped_pending = 0.
REQ-033 Pedestrian pulse at GREEN count 6 (past the minimum) -> GREEN exits at the next edge; AMBER lasts 4 cycles.
REQ-034 Pedestrian held high for 30 cycles across several phases -> exactly one request is served; ped_walk is high for one RED phase only.
REQ-035 Pedestrian edge in the AMBER -> RED transition cycle -> ped_walk = 1, ped_pending = 0; the next GREEN runs the full 8 cycles.
REQ-036 Reset asserted at AMBER count 2 with ped_pending = 1 -> outputs immediately show currColour = 00, counter_clear = 1, ped_pending = 0, ped_walk = 0; after release, a full 10-cycle RED.
